// File: rtl/shuffler_ctrl.sv
// Sequencing controller for the 3-parallel FFT data shuffler: phase counter, one-hot
// mux select, delay-line shift enable, fill/drain handling and output valid/sof flags.
module shuffler_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic       sync_in,
  input  logic       last_in,
  output logic       ready_out,
  output logic       en_out,
  output logic [2:0] sel,
  output logic       valid_out,
  output logic       sof_out,
  output logic       busy
);

  localparam int CW = $clog2(3 * DEPTH);
  localparam int KW = $clog2(2 * DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(3 * DEPTH - 1);
  localparam logic [CW-1:0] PH1     = CW'(DEPTH);
  localparam logic [CW-1:0] PH2     = CW'(2 * DEPTH);
  localparam logic [KW-1:0] K_FULL  = KW'(2 * DEPTH);
  localparam logic [KW-1:0] D_LAST  = KW'(2 * DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] d_q, d_d;
  logic [KW-1:0] kdrain_q, kdrain_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          pend_q, pend_d;
  logic          accept;
  logic [KW-1:0] k_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      d_q      <= '0;
      kdrain_q <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      d_q      <= d_d;
      kdrain_q <= kdrain_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    d_d      = d_q;
    kdrain_d = kdrain_q;
    pend_d   = pend_q;
    k_acc    = k_q;

    ready_out = (state_q != DRAIN);
    busy      = (state_q != IDLE);
    accept    = valid_in & ready_out & ((state_q != IDLE) | sync_in);
    en_out    = accept | (state_q == DRAIN);

    if (en_out) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end

    // A sync sample starts a new frame; the old frame's remaining outputs are dropped.
    valid_d = (en_out & (state_q == RUN) & ~(accept & sync_in)) |
              ((state_q == DRAIN) & (d_q >= (K_FULL - kdrain_q)));
    sof_d   = valid_d & pend_q;
    if (valid_d) begin
      pend_d = 1'b0;
    end

    case (state_q)
      IDLE, FILL, RUN: begin
        if (accept) begin
          if (sync_in) begin
            cnt_d   = CW'(1);
            k_acc   = KW'(1);
            pend_d  = 1'b1;
            state_d = FILL;
          end else begin
            k_acc = (k_q == K_FULL) ? k_q : k_q + 1'b1;
            if (state_q == FILL && k_acc == K_FULL) begin
              state_d = RUN;
            end
          end
          k_d = k_acc;
          // last_in wins over the FILL->RUN move.
          if (last_in) begin
            state_d  = DRAIN;
            d_d      = '0;
            kdrain_d = k_acc;
          end
        end
      end
      DRAIN: begin
        d_d = d_q + 1'b1;
        if (d_q == D_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          k_d     = '0;
          d_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (cnt_q < PH1) begin
      sel = 3'b001;
    end else if (cnt_q < PH2) begin
      sel = 3'b010;
    end else begin
      sel = 3'b100;
    end
  end

  assign valid_out = valid_q;
  assign sof_out   = sof_q;

endmodule

// File: tb/tb_shuffler_ctrl.sv
// Self-checking bench for shuffler_ctrl: a vector table for the short-frame corner case,
// directed frame sequences and random traffic against a sample-counting reference model.
module tb_shuffler_ctrl;
  localparam int DEPTH = 4;
  localparam int L     = 3 * DEPTH;
  localparam int F     = 2 * DEPTH;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in, sync_in, last_in;
  logic       ready_out, en_out, valid_out, sof_out, busy;
  logic [2:0] sel;

  always #5 clk = ~clk;

  shuffler_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sync_in(sync_in), .last_in(last_in),
    .ready_out(ready_out), .en_out(en_out), .sel(sel), .valid_out(valid_out),
    .sof_out(sof_out), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: counts samples accepted (m_n) and emitted (m_m) in the current frame.
  bit m_active, m_drain, m_valid, m_sof;
  int m_left, m_n, m_m, m_pos;
  int cyc = 0;
  int vcnt, sofcnt, drain_cycles;
  int last_sync_cyc, first_valid_cyc, last_cyc, busy_fall_cyc;
  bit busy_prev;
  bit cur_v, cur_s, cur_l;

  typedef struct {
    bit       v, s, l;
    bit       rdy, en, bsy, vo, sof;
    bit [2:0] sel;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_drain = 0; m_valid = 0; m_sof = 0;
    m_left = 0; m_n = 0; m_m = 0; m_pos = 0;
  endfunction

  function automatic bit model_accept(input bit v, input bit s);
    return v && !m_drain && (m_active || s);
  endfunction

  task automatic drive_and_check(input bit v, input bit s, input bit l);
    bit acc;
    cur_v = v; cur_s = s; cur_l = l;
    valid_in = v; sync_in = s; last_in = l;
    #3;
    acc = model_accept(v, s);
    chk("ready_out", ready_out, !m_drain);
    chk("en_out", en_out, acc || m_drain);
    chk("busy", busy, m_active || m_drain);
    chk("sel", sel, 3'b001 << (m_pos / DEPTH));
    chk("valid_out", valid_out, m_valid);
    chk("sof_out", sof_out, m_sof);
    if (valid_out) vcnt++;
    if (sof_out) sofcnt++;
    if (!ready_out) drain_cycles++;
    if (valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
  endtask

  task automatic advance();
    bit acc, nv, ns;
    acc = model_accept(cur_v, cur_s);
    nv = 0; ns = 0;
    if (m_drain) begin
      if (m_left <= m_n - m_m) begin
        nv = 1; ns = (m_m == 0); m_m++;
      end
      m_left--;
      m_pos = (m_pos + 1) % L;
      if (m_left == 0) begin
        m_drain = 0; m_active = 0; m_pos = 0;
      end
    end else if (acc) begin
      m_pos = (m_pos + 1) % L;
      if (cur_s) begin
        m_n = 1; m_m = 0; m_active = 1; m_pos = 1;
        last_sync_cyc = cyc; first_valid_cyc = -1;
      end else begin
        m_n++;
        if (m_n > F) begin
          nv = 1; ns = (m_m == 0); m_m++;
        end
      end
      if (cur_l) begin
        m_drain = 1; m_left = F; last_cyc = cyc;
      end
    end
    m_valid = nv; m_sof = ns;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit v, input bit s, input bit l);
    drive_and_check(v, s, l);
    advance();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1; valid_in = 0; sync_in = 0; last_in = 0;
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_sof_out", sof_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_en_out", en_out, 0);
    chk("rst_sel", sel, 3'b001);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    busy_prev = 0;
  endtask

  task automatic frame(input int n, input bit gaps);
    int i = 0;
    int c = 0;
    while (i < n) begin
      if (gaps && (c % 3 == 2)) begin
        cycle(0, 0, 0);
      end else begin
        cycle(1, i == 0, i == n - 1);
        i++;
      end
      c++;
    end
  endtask

  task automatic clear_stats();
    vcnt = 0; sofcnt = 0; drain_cycles = 0;
    first_valid_cyc = -1; last_sync_cyc = 0; last_cyc = 0; busy_fall_cyc = -1;
  endtask

  initial begin
    //          v  s  l  rdy en bsy vo sof sel
    tbl[0]  = '{1, 1, 0, 1,  1, 0,  0, 0, 3'b001};
    tbl[1]  = '{1, 0, 0, 1,  1, 1,  0, 0, 3'b001};
    tbl[2]  = '{1, 0, 1, 1,  1, 1,  0, 0, 3'b001};
    tbl[3]  = '{0, 0, 0, 0,  1, 1,  0, 0, 3'b001};
    tbl[4]  = '{0, 0, 0, 0,  1, 1,  0, 0, 3'b010};
    tbl[5]  = '{1, 0, 0, 0,  1, 1,  0, 0, 3'b010};
    tbl[6]  = '{0, 0, 0, 0,  1, 1,  0, 0, 3'b010};
    tbl[7]  = '{0, 0, 0, 0,  1, 1,  0, 0, 3'b010};
    tbl[8]  = '{0, 0, 0, 0,  1, 1,  0, 0, 3'b100};
    tbl[9]  = '{0, 0, 0, 0,  1, 1,  1, 1, 3'b100};
    tbl[10] = '{0, 0, 0, 0,  1, 1,  1, 0, 3'b100};
    tbl[11] = '{1, 0, 0, 1,  0, 0,  1, 0, 3'b001};
    tbl[12] = '{1, 0, 0, 1,  0, 0,  0, 0, 3'b001};

    rst = 1'b0; valid_in = 0; sync_in = 0; last_in = 0;
    model_reset();
    clear_stats();
    busy_prev = 0;
    @(posedge clk);
    #1;
    do_reset();
    cycle(0, 0, 0);

    // Short frame: FILL -> DRAIN, outputs only on the last three drain cycles.
    clear_stats();
    for (int r = 0; r < 13; r++) begin
      drive_and_check(tbl[r].v, tbl[r].s, tbl[r].l);
      chk($sformatf("tbl%0d_ready", r), ready_out, tbl[r].rdy);
      chk($sformatf("tbl%0d_en", r), en_out, tbl[r].en);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
      chk($sformatf("tbl%0d_valid", r), valid_out, tbl[r].vo);
      chk($sformatf("tbl%0d_sof", r), sof_out, tbl[r].sof);
      chk($sformatf("tbl%0d_sel", r), sel, tbl[r].sel);
      advance();
    end
    chk("short_vcnt", vcnt, 3);

    // Full contiguous 24-sample frame.
    do_reset();
    clear_stats();
    frame(24, 0);
    repeat (F + 2) cycle(0, 0, 0);
    chk("full_vcnt", vcnt, 24);
    chk("full_sofcnt", sofcnt, 1);
    chk("full_first_latency", first_valid_cyc - last_sync_cyc, F + 1);
    chk("full_drain_len", drain_cycles, F);
    chk("full_busy_drop", busy_fall_cyc - last_cyc, F + 1);

    // Same frame with a gap every third cycle.
    clear_stats();
    frame(24, 1);
    repeat (F + 2) cycle(0, 0, 0);
    chk("gap_vcnt", vcnt, 24);
    chk("gap_sofcnt", sofcnt, 1);
    chk("gap_busy_drop", busy_fall_cyc - last_cyc, F + 1);

    // Resync on sample 15 during RUN.
    clear_stats();
    for (int i = 0; i < 15; i++) cycle(1, i == 0, 0);
    cycle(1, 1, 0);
    chk("resync_busy", busy, 1);
    for (int i = 1; i < 12; i++) cycle(1, 0, i == 11);
    repeat (F + 2) cycle(0, 0, 0);
    chk("resync_latency", first_valid_cyc - last_sync_cyc, F + 1);
    chk("resync_sofcnt", sofcnt, 2);
    chk("resync_vcnt", vcnt, 7 + 12);

    // Asynchronous reset at drain cycle d=3, then stray valid without sync.
    clear_stats();
    frame(24, 0);
    repeat (3) cycle(0, 0, 0);
    chk("pre_rst_valid", valid_out, 1);
    do_reset();
    clear_stats();
    repeat (5) cycle(1, 0, 0);
    repeat (4) cycle(0, 0, 0);
    chk("post_rst_vcnt", vcnt, 0);
    chk("post_rst_busy", busy, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 600) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0,
              $urandom_range(0, 40) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
